// File: rtl/mem_copy_dma_pkg.sv
// rtl/mem_copy_dma_pkg.sv - bus command encodings and DMA state type shared with the CPU
package mem_copy_dma_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/mem_copy_dma_if.sv
// rtl/mem_copy_dma_if.sv - shared memory bus: command, address, read and write data
interface mem_copy_dma_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);

  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] write_data;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data
  );

endinterface

// File: rtl/LE_reg.sv
// rtl/LE_reg.sv - load-enabled register with synchronous active-high clear
module LE_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             le,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (le) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - bus initiator copying count words from src to dst, one word per RD/RDW/WR trio
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  mem_copy_dma_if.master    bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  dma_state_e        state_q;
  dma_state_e        state_d;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] src_d;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] dst_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              load_word;
  logic [DATA_W-1:0] word_q;

  // RAM returns data one cycle after MREAD, so the word is valid throughout RDW
  assign load_word = (state_q == RDW);

  LE_reg #(DATA_W) u_word_reg (
    .clk   (clk),
    .reset (reset),
    .le    (load_word),
    .d     (bus.read_data),
    .q     (word_q)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = count;
          state_d = (count != '0) ? RD : FIN;
        end
      end
      RD:  state_d = RDW;
      RDW: state_d = WR;
      WR: begin
        // pointers wrap naturally at the address width
        src_d   = src_q + ADDR_ONE;
        dst_d   = dst_q + ADDR_ONE;
        cnt_d   = cnt_q - ADDR_ONE;
        state_d = (cnt_q != ADDR_ONE) ? RD : FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    busy           = (state_q != IDLE);
    done           = (state_q == FIN);
    bus.mem_cmd    = MNONE;
    bus.mem_addr   = '0;
    bus.write_data = word_q;
    case (state_q)
      RD, RDW: begin
        bus.mem_cmd  = MREAD;
        bus.mem_addr = src_q;
      end
      WR: begin
        bus.mem_cmd  = MWRITE;
        bus.mem_addr = dst_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - randomized self-checking bench for mem_copy_dma against a word-copy model
module tb_mem_copy_dma;

  localparam int AW        = 9;
  localparam int DW        = 16;
  localparam int MEM_WORDS = 1 << AW;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          start    = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW-1:0] count    = '0;
  logic          busy;
  logic          done;

  mem_copy_dma_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // synchronous RAM responder; preload port lets the bench seed contents
  logic [DW-1:0] mem     [MEM_WORDS];
  logic [DW-1:0] ref_mem [MEM_WORDS];
  logic [DW-1:0] rd_q     = '0;
  logic          pre_en   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.mem_cmd == 2'b10) mem[bus.mem_addr] <= bus.write_data;
    if (bus.mem_cmd == 2'b01) rd_q <= mem[bus.mem_addr];
  end
  assign bus.read_data = rd_q;

  // bus monitor: logs read starts and writes, counts protocol violations
  int            mon_bad  = 0;
  logic [1:0]    prev_cmd = 2'b00;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wa_log[$];
  logic [DW-1:0] wd_log[$];

  always @(negedge clk) begin
    if (bus.mem_cmd === 2'b11) mon_bad <= mon_bad + 1;
    else if (bus.mem_cmd === 2'b10 && prev_cmd === 2'b10) mon_bad <= mon_bad + 1;
    if (bus.mem_cmd === 2'b01 && prev_cmd !== 2'b01) rd_log.push_back(bus.mem_addr);
    if (bus.mem_cmd === 2'b10) begin
      wa_log.push_back(bus.mem_addr);
      wd_log.push_back(bus.write_data);
    end
    prev_cmd <= bus.mem_cmd;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic poke_mem(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = v; ref_mem[a] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Runs one transfer; poke_at issues a stray start at that cycle, abort_at asserts reset then.
  task automatic run_copy(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] n, input int poke_at, input int abort_at);
    int            n_rd, n_wr, k, done_at, done_n, busy_n, exp_cyc;
    bit            finished;
    logic [AW-1:0] a;
    logic [AW-1:0] exp_rd[$];
    logic [AW-1:0] exp_wa[$];
    logic [DW-1:0] exp_wd[$];

    n_rd = int'(n);
    n_wr = int'(n);
    if (abort_at > 0) begin
      n_rd = ((abort_at + 2) / 3 < n_rd) ? (abort_at + 2) / 3 : n_rd;
      n_wr = (abort_at / 3 < n_wr) ? abort_at / 3 : n_wr;
    end
    for (int i = 0; i < n_rd; i++) begin
      a = s + AW'(i);
      exp_rd.push_back(a);
    end
    for (int i = 0; i < n_wr; i++) begin
      a = d + AW'(i);
      ref_mem[a] = ref_mem[s + AW'(i)];
      exp_wa.push_back(a);
      exp_wd.push_back(ref_mem[a]);
    end
    exp_cyc = (n == '0) ? 1 : 3 * int'(n) + 1;

    rd_log.delete(); wa_log.delete(); wd_log.delete();
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; count = n;
    @(negedge clk);
    start = 1'b0; src_addr = AW'($urandom); dst_addr = AW'($urandom); count = AW'($urandom);
    k = 1; done_at = 0; done_n = 0; busy_n = 0; finished = 1'b0;
    while (!finished && k <= 3 * int'(n) + 10) begin
      if (done === 1'b1) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      if (busy === 1'b1) busy_n++;
      else finished = 1'b1;
      if (!finished) begin
        if (k == poke_at) begin
          start = 1'b1; src_addr = s ^ 9'h0A5; dst_addr = d ^ 9'h15A; count = n + 9'd2;
        end
        if (k == poke_at + 1) start = 1'b0;
        if (k == abort_at) reset = 1'b1;
        @(negedge clk);
        k++;
      end
    end

    check({tag, ":returned_idle"}, 32'(finished), 32'd1);
    if (abort_at > 0) begin
      check({tag, ":idle_cycle_after_reset"}, k, abort_at + 1);
      check({tag, ":wdata_cleared"}, 32'(bus.write_data), 32'd0);
      check({tag, ":no_done"}, done_n, 0);
      reset = 1'b0;
    end else begin
      check({tag, ":done_cycle"}, done_at, exp_cyc);
      check({tag, ":done_pulses"}, done_n, 1);
      check({tag, ":busy_cycles"}, busy_n, exp_cyc);
    end
    check({tag, ":read_count"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check($sformatf("%s:read_addr[%0d]", tag, i), 32'(rd_log[i]), 32'(exp_rd[i]));
    check({tag, ":write_count"}, wa_log.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size() && i < wa_log.size(); i++) begin
      check($sformatf("%s:write_addr[%0d]", tag, i), 32'(wa_log[i]), 32'(exp_wa[i]));
      check($sformatf("%s:write_data[%0d]", tag, i), 32'(wd_log[i]), 32'(exp_wd[i]));
    end
    check({tag, ":mem_diffs"}, mem_diffs(), 0);
  endtask

  initial begin
    logic [AW-1:0] rs, rdst, rn;

    for (int i = 0; i < MEM_WORDS; i++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_addr = AW'(i); pre_data = DW'($urandom); ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_en = 1'b0;

    check("reset:busy", 32'(busy), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:mem_cmd", 32'(bus.mem_cmd), 32'd0);
    check("reset:mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset:write_data", 32'(bus.write_data), 32'd0);

    // reset wins over a simultaneous start
    @(negedge clk);
    start = 1'b1; src_addr = 9'h010; dst_addr = 9'h020; count = 9'd3;
    @(negedge clk);
    check("reset_priority:busy", 32'(busy), 32'd0);
    start = 1'b0; reset = 1'b0;

    poke_mem(9'h010, 16'hAAAA);
    poke_mem(9'h011, 16'hBBBB);
    poke_mem(9'h012, 16'hCCCC);
    run_copy("copy3", 9'h010, 9'h020, 9'd3, 0, 0);
    check("copy3:dst0", 32'(mem[9'h020]), 32'hAAAA);
    check("copy3:dst2", 32'(mem[9'h022]), 32'hCCCC);

    run_copy("zero", 9'h040, 9'h050, 9'd0, 0, 0);
    run_copy("wrap", 9'h1FE, 9'h0F0, 9'd4, 0, 0);
    run_copy("busy_start", 9'h080, 9'h0A0, 9'd5, 4, 0);
    run_copy("abort", 9'h100, 9'h140, 9'd3, 0, 5);
    run_copy("after_abort", 9'h100, 9'h140, 9'd3, 0, 0);
    run_copy("overlap_up", 9'h060, 9'h062, 9'd6, 0, 0);
    run_copy("dst_wrap", 9'h030, 9'h1FD, 9'd5, 0, 0);

    for (int t = 0; t < 6; t++) begin
      rs   = AW'($urandom);
      rn   = AW'($urandom_range(1, 12));
      rdst = ($urandom_range(0, 1) == 1) ? rs + AW'($urandom_range(0, 4)) : AW'($urandom);
      run_copy($sformatf("rand%0d", t), rs, rdst, rn, 0, 0);
    end

    check("monitor:bus_violations", mon_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, giving the bus address width.
REQ-002 SHALL have parameter DATA_W, default 16, giving the bus data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: requests a copy; sampled only in IDLE.
REQ-006 SHALL have port src_addr, input, ADDR_W: first source word address; captured on an accepted start.
REQ-007 SHALL have port dst_addr, input, ADDR_W: first destination word address; captured on an accepted start.
REQ-008 SHALL have port count, input, ADDR_W: number of words to copy; captured on an accepted start.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a transfer finishes.
REQ-011 SHALL have port mem_cmd, output, 2 bits: bus command, one of MNONE, MREAD or MWRITE.
REQ-012 SHALL have port mem_addr, output, ADDR_W: bus address.
REQ-013 SHALL have port read_data, input, DATA_W: shared tri-stated read bus.
REQ-014 SHALL have port write_data, output, DATA_W: bus write data.

Function
REQ-015 SHALL be the bus initiator; it drives the same mem_cmd / mem_addr / write_data / read_data protocol as the CPU. Memory and I/O decode are the responders.
REQ-016 SHALL implement a Moore FSM with states IDLE, RD, RDW, WR, FIN; all outputs are decoded from registered state only.
REQ-017 IDLE: mem_cmd=MNONE. On start=1, capture src_addr, dst_addr and count, then:
- go to RD if count!=0;
- go to FIN if count==0, with no bus cycle issued.
REQ-018 RD: mem_cmd=MREAD, mem_addr=current source pointer. Go to RDW.
REQ-019 RDW: hold MREAD and the same address, since the RAM read is synchronous (1-cycle latency). Latch read_data at the end of RDW. Go to WR.
REQ-020 WR: mem_cmd=MWRITE, mem_addr=current destination pointer, write_data=latched word, for exactly one cycle. Then:
- increment both pointers;
- decrement the remaining count;
- go to RD if remaining count!=0, else go to FIN.
REQ-021 FIN: done=1, mem_cmd=MNONE. Go to IDLE.
REQ-022 A word costs exactly 3 cycles. A transfer of N>0 words goes from start accepted to done high in 3N+1 cycles, plus 1 cycle back to IDLE.
REQ-023 Pointers SHALL wrap modulo 2^ADDR_W (0x1FF+1 -> 0x000). No error is flagged on wrap.
REQ-024 start SHALL be ignored while busy; inputs changing mid-transfer have no effect.
REQ-025 Source and destination ranges MAY overlap. The copy order is strictly ascending, with no overlap correction.
REQ-026 Outside WR, write_data SHALL hold the last latched word, and mem_addr SHALL be 0 in IDLE and FIN.
REQ-027 The block SHALL NOT drive read_data under any condition.

Reset
REQ-028 On reset=1 at a clock edge, the block SHALL, from any state, set:
- state=IDLE, mem_cmd=MNONE, mem_addr=0;
- write_data=0, busy=0, done=0;
- pointers=0, count=0.
REQ-029 When reset aborts a transfer mid-word, the block SHALL leave any write not yet issued un-issued and SHALL NOT pulse done.
REQ-030 reset SHALL take priority over start in the same cycle.

Structure
REQ-031 The MNONE/MREAD/MWRITE encodings (00/01/10) and the FSM state enum SHALL live in a shared package used by both the CPU and this block.
REQ-032 The data latch SHALL reuse the existing load-enabled register, LE_reg #(DATA_W), loaded in RDW; no other sub-module is needed.

Verification
REQ-033 Copy test: with RAM preloaded 0x010..0x012 = 0xAAAA, 0xBBBB, 0xCCCC, apply start with src=0x010, dst=0x020, count=3. Required: 0x020..0x022 match, done pulses exactly once at cycle 10, busy is high for 10 cycles.
REQ-034 Zero count: start with count=0. Required: no MREAD or MWRITE observed, done pulses one cycle after start, memory unchanged.
REQ-035 Wrap-around: start with src=0x1FE, dst=0x0F0, count=4. Required: reads from 0x1FE, 0x1FF, 0x000, 0x001, in that order.
REQ-036 Abort: assert reset in RDW of the second word of a 3-word copy. Required: only the first destination word is written, done never pulses, busy=0 on the next cycle.
REQ-037 Busy start: pulse start mid-transfer with different addresses. Required: no effect, and the original transfer completes unchanged.
REQ-038 Bus check: on every cycle, the monitor SHALL confirm mem_cmd is never 2'b11 and that each MWRITE lasts exactly one cycle.
